// File: rtl/ibex_if_pkg.sv
// Shared types for the IF-stage fetch sequencer: PC selectors, FSM states and fetch buffer.
package ibex_if_pkg;

  typedef enum logic [2:0] {
    PC_BOOT = 3'd0,
    PC_JUMP = 3'd1,
    PC_EXC  = 3'd2,
    PC_ERET = 3'd3,
    PC_DRET = 3'd4
  } pc_sel_e;

  typedef enum logic [1:0] {
    EXC_PC_EXC     = 2'd0,
    EXC_PC_IRQ     = 2'd1,
    EXC_PC_DBD     = 2'd2,
    EXC_PC_DBG_EXC = 2'd3
  } exc_pc_sel_e;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_REQ     = 2'd1,
    IF_WAIT    = 2'd2,
    IF_DISCARD = 2'd3
  } if_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic        err;
    logic [31:0] pc;
  } fetch_buf_t;

  function automatic logic is_compressed(input logic [31:0] instr);
    return instr[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_if_pc_mux.sv
// Combinational redirect-target selection; result is always halfword aligned.
module ibex_if_pc_mux
  import ibex_if_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR    = 32'h0000_0000,
  parameter logic [31:0] DM_HALT_ADDR = 32'h1A11_0800,
  parameter logic [31:0] DM_EXC_ADDR  = 32'h1A11_0808
) (
  input  logic [2:0]  pc_mux,
  input  logic [1:0]  exc_pc_mux,
  input  logic [5:0]  exc_cause,
  input  logic [31:0] branch_target,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [31:0] depc,
  output logic [31:0] target
);

  logic [31:0] mtvec_base;
  logic [31:0] exc_target;
  logic [31:0] raw;
  logic        unused_bits;

  assign mtvec_base = {mtvec[31:2], 2'b00};

  always_comb begin
    exc_target = mtvec_base;
    case (exc_pc_mux)
      EXC_PC_EXC:     exc_target = mtvec_base;
      EXC_PC_IRQ:     exc_target = mtvec_base + {25'd0, exc_cause[4:0], 2'b00};
      EXC_PC_DBD:     exc_target = DM_HALT_ADDR;
      EXC_PC_DBG_EXC: exc_target = DM_EXC_ADDR;
      default:        exc_target = mtvec_base;
    endcase
  end

  // Unused encodings 5-7 fall back to the boot vector.
  always_comb begin
    raw = BOOT_ADDR + 32'h80;
    case (pc_mux)
      PC_BOOT: raw = BOOT_ADDR + 32'h80;
      PC_JUMP: raw = branch_target;
      PC_EXC:  raw = exc_target;
      PC_ERET: raw = mepc;
      PC_DRET: raw = depc;
      default: raw = BOOT_ADDR + 32'h80;
    endcase
  end

  assign target      = {raw[31:1], 1'b0};
  assign unused_bits = ^{exc_cause[5], mtvec[1:0], raw[0]};

endmodule

// File: rtl/ibex_if_sequencer.sv
// IF-stage fetch sequencer: single-outstanding req/gnt/rvalid fetch into a one-entry buffer.
// Optional IBEX_IF_PERF_CNT_EN adds fetch/discard performance counters.
module ibex_if_sequencer
  import ibex_if_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR    = 32'h0000_0000,
  parameter logic [31:0] DM_HALT_ADDR = 32'h1A11_0800,
  parameter logic [31:0] DM_EXC_ADDR  = 32'h1A11_0808
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic        pc_set_i,
  input  logic [2:0]  pc_mux_i,
  input  logic [1:0]  exc_pc_mux_i,
  input  logic [5:0]  exc_cause_i,
  input  logic        instr_valid_clear_i,
  input  logic        id_in_ready_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_depc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
`ifdef IBEX_IF_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt_o,
  output logic [15:0] perf_discard_cnt_o,
`endif
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [15:0] instr_compressed_o,
  output logic        instr_is_compressed_o,
  output logic        instr_fetch_err_o,
  output logic [31:0] pc_id_o
);

  localparam logic [31:0] BOOT_PC = BOOT_ADDR + 32'h80;

  if_state_e   state_q, state_d;
  fetch_buf_t  buf_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] target;
  logic [31:0] pc_step;
  logic        req_hold_q;
  logic        err_halt_q;
  logic        flush;
  logic        can_issue;
  logic        grant;
  logic        load;

  ibex_if_pc_mux #(
    .BOOT_ADDR   (BOOT_ADDR),
    .DM_HALT_ADDR(DM_HALT_ADDR),
    .DM_EXC_ADDR (DM_EXC_ADDR)
  ) u_pc_mux (
    .pc_mux       (pc_mux_i),
    .exc_pc_mux   (exc_pc_mux_i),
    .exc_cause    (exc_cause_i),
    .branch_target(branch_target_i),
    .mtvec        (csr_mtvec_i),
    .mepc         (csr_mepc_i),
    .depc         (csr_depc_i),
    .target       (target)
  );

  assign flush = pc_set_i | instr_valid_clear_i;

  // A fresh request needs room in the buffer; after a fetch error only a redirect restarts fetching.
  assign can_issue = (~buf_q.valid | id_in_ready_i | flush) & (~err_halt_q | pc_set_i);

  // Once presented, a request is held until granted (req_hold_q).
  assign mem_req_o  = (state_q == IF_REQ) & (req_hold_q | can_issue);
  assign mem_addr_o = pc_set_i ? target : fetch_pc_q;
  assign grant      = mem_req_o & mem_gnt_i;
  assign load       = mem_rvalid_i & (state_q == IF_WAIT) & ~flush;
  assign pc_step    = is_compressed(mem_rdata_i) ? 32'd2 : 32'd4;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IF_IDLE: if (instr_req_i && can_issue) state_d = IF_REQ;
      IF_REQ: begin
        if (grant)                          state_d = IF_WAIT;
        else if (!mem_req_o && !instr_req_i) state_d = IF_IDLE;
      end
      IF_WAIT: begin
        if (mem_rvalid_i)  state_d = (instr_req_i && !(load && mem_err_i)) ? IF_REQ : IF_IDLE;
        else if (pc_set_i) state_d = IF_DISCARD;
      end
      IF_DISCARD: if (mem_rvalid_i) state_d = IF_REQ;
      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IF_IDLE;
      fetch_pc_q <= BOOT_PC;
      buf_q      <= '0;
      req_hold_q <= 1'b0;
      err_halt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_hold_q <= mem_req_o & ~mem_gnt_i;

      if (pc_set_i)                  fetch_pc_q <= target;
      else if (load && !mem_err_i)   fetch_pc_q <= fetch_pc_q + pc_step;

      if (pc_set_i)                  err_halt_q <= 1'b0;
      else if (load && mem_err_i)    err_halt_q <= 1'b1;

      if (flush)              buf_q.valid <= 1'b0;
      else if (load)          buf_q <= '{valid: 1'b1,
                                         instr: mem_err_i ? 32'd0 : mem_rdata_i,
                                         err:   mem_err_i,
                                         pc:    fetch_pc_q};
      else if (id_in_ready_i) buf_q.valid <= 1'b0;
    end
  end

  assign instr_valid_o         = buf_q.valid;
  assign instr_o               = buf_q.instr;
  assign instr_compressed_o    = buf_q.instr[15:0];
  assign instr_is_compressed_o = buf_q.valid & is_compressed(buf_q.instr);
  assign instr_fetch_err_o     = buf_q.valid & buf_q.err;
  assign pc_id_o               = buf_q.pc;

`ifdef IBEX_IF_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetch_cnt_o   <= 32'd0;
      perf_discard_cnt_o <= 16'd0;
    end else begin
      if (load) perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      if (state_q == IF_DISCARD && mem_rvalid_i && perf_discard_cnt_o != 16'hFFFF)
        perf_discard_cnt_o <= perf_discard_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ibex_if_sequencer.sv
// Bench for ibex_if_sequencer: bus responder with a response scoreboard, plus a redirect-target table.
module tb_ibex_if_sequencer;
  import ibex_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_i, pc_set_i, instr_valid_clear_i, id_in_ready_i;
  logic [2:0]  pc_mux_i;
  logic [1:0]  exc_pc_mux_i;
  logic [5:0]  exc_cause_i;
  logic [31:0] branch_target_i, csr_mtvec_i, csr_mepc_i, csr_depc_i;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_addr_o, mem_rdata_i;
  logic        instr_valid_o, instr_is_compressed_o, instr_fetch_err_o;
  logic [31:0] instr_o, pc_id_o;
  logic [15:0] instr_compressed_o;
`ifdef IBEX_IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [15:0] perf_discard_cnt_o;
`endif

  always #5 clk = ~clk;

  ibex_if_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req_i), .pc_set_i(pc_set_i), .pc_mux_i(pc_mux_i),
    .exc_pc_mux_i(exc_pc_mux_i), .exc_cause_i(exc_cause_i),
    .instr_valid_clear_i(instr_valid_clear_i), .id_in_ready_i(id_in_ready_i),
    .branch_target_i(branch_target_i), .csr_mtvec_i(csr_mtvec_i),
    .csr_mepc_i(csr_mepc_i), .csr_depc_i(csr_depc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
`ifdef IBEX_IF_PERF_CNT_EN
    .perf_fetch_cnt_o(perf_fetch_cnt_o), .perf_discard_cnt_o(perf_discard_cnt_o),
`endif
    .instr_valid_o(instr_valid_o), .instr_o(instr_o),
    .instr_compressed_o(instr_compressed_o),
    .instr_is_compressed_o(instr_is_compressed_o),
    .instr_fetch_err_o(instr_fetch_err_o), .pc_id_o(pc_id_o)
  );

  typedef struct {
    logic [2:0]  pc_mux;
    logic [1:0]  exc_mux;
    logic [5:0]  cause;
    logic [31:0] mtvec, target, mepc, depc, exp;
  } redir_vec_t;

  typedef struct {
    logic [31:0] pc, instr;
    logic        err;
  } exp_t;

  redir_vec_t  vecs [10];
  exp_t        sb [$];
  int          n_cmp = 0, n_bad = 0;
  logic        gnt_en, sb_en, pend;
  int          rsp_delay, pend_cnt;
  logic [31:0] pend_addr, rsp_addr;
  logic        s_req, s_gnt;
  logic [31:0] s_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h84:  return 32'h0000_4501;
      32'h86:  return 32'h0000_0001;
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic logic errf(input logic [31:0] a);
    return a == 32'h88;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock: grant, snapshot at negedge, scoreboard pop and responder update after posedge.
  task automatic tick();
    exp_t e;
    logic pushed;
    pushed = 1'b0;
    #1 mem_gnt_i = gnt_en & mem_req_o;
    @(negedge clk);
    s_req  = mem_req_o;
    s_addr = mem_addr_o;
    s_gnt  = mem_gnt_i;
    if (mem_rvalid_i && sb_en && !pc_set_i && !instr_valid_clear_i) begin
      e.pc    = rsp_addr;
      e.err   = errf(rsp_addr);
      e.instr = e.err ? 32'd0 : memf(rsp_addr);
      sb.push_back(e);
      pushed = 1'b1;
    end
    @(posedge clk);
    #1;
    mem_gnt_i = 1'b0;
    if (pushed && sb.size() > 0) begin
      e = sb.pop_front();
      check1 ("rsp_valid", instr_valid_o, 1'b1);
      check32("rsp_pc", pc_id_o, e.pc);
      check32("rsp_instr", instr_o, e.instr);
      check1 ("rsp_err", instr_fetch_err_o, e.err);
    end
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    mem_rdata_i  = 32'd0;
    if (s_gnt) begin
      pend      = 1'b1;
      pend_cnt  = rsp_delay;
      pend_addr = s_addr;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend         = 1'b0;
        rsp_addr     = pend_addr;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = memf(pend_addr);
        mem_err_i    = errf(pend_addr);
      end
    end
  endtask

  task automatic wait_grant(input string name, input logic [31:0] exp_addr);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = s_gnt;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no grant within 20 cycles, expected addr %h", name, exp_addr);
    end else begin
      check32(name, s_addr, exp_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    instr_req_i = 0; pc_set_i = 0; instr_valid_clear_i = 0; id_in_ready_i = 0;
    pc_mux_i = 0; exc_pc_mux_i = 0; exc_cause_i = 0;
    branch_target_i = 0; csr_mtvec_i = 0; csr_mepc_i = 0; csr_depc_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0;
    gnt_en = 1; sb_en = 1; rsp_delay = 1; pend = 0; pend_cnt = 0;
    pend_addr = 0; rsp_addr = 0;

    vecs[0] = '{3'd0, 2'd0, 6'd0,  32'h0,    32'h0,    32'h0,         32'h0,         32'h0000_0080};
    vecs[1] = '{3'd1, 2'd0, 6'd0,  32'h0,    32'h1235, 32'h0,         32'h0,         32'h0000_1234};
    vecs[2] = '{3'd3, 2'd0, 6'd0,  32'h0,    32'h0,    32'h4000_0003, 32'h0,         32'h4000_0002};
    vecs[3] = '{3'd4, 2'd0, 6'd0,  32'h0,    32'h0,    32'h0,         32'h8000_0010, 32'h8000_0010};
    vecs[4] = '{3'd2, 2'd0, 6'd0,  32'h2003, 32'h0,    32'h0,         32'h0,         32'h0000_2000};
    vecs[5] = '{3'd2, 2'd1, 6'h3F, 32'h2001, 32'h0,    32'h0,         32'h0,         32'h0000_207C};
    vecs[6] = '{3'd2, 2'd2, 6'd0,  32'h0,    32'h0,    32'h0,         32'h0,         32'h1A11_0800};
    vecs[7] = '{3'd2, 2'd3, 6'd0,  32'h0,    32'h0,    32'h0,         32'h0,         32'h1A11_0808};
    vecs[8] = '{3'd5, 2'd0, 6'd0,  32'h0,    32'h5555, 32'h0,         32'h0,         32'h0000_0080};
    vecs[9] = '{3'd7, 2'd0, 6'd0,  32'h0,    32'h5555, 32'h0,         32'h0,         32'h0000_0080};

    repeat (2) @(posedge clk);
    #1;
    check1 ("rst_req", mem_req_o, 1'b0);
    check32("rst_addr", mem_addr_o, 32'h80);
    check1 ("rst_valid", instr_valid_o, 1'b0);
    check32("rst_instr", instr_o, 32'h0);
    check32("rst_pc_id", pc_id_o, 32'h0);
    check1 ("rst_err", instr_fetch_err_o, 1'b0);
    check1 ("rst_is_c", instr_is_compressed_o, 1'b0);

    rst = 1'b0;
    instr_req_i = 1'b1;
    wait_grant("boot_addr", 32'h80);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("full_no_req", s_req, 1'b0);
    end
    id_in_ready_i = 1'b1;
    tick();
    check1 ("ready_req", s_req, 1'b1);
    check32("next_84", s_addr, 32'h84);

    id_in_ready_i = 1'b0;
    tick();
    check1 ("is_compressed", instr_is_compressed_o, 1'b1);
    check32("compressed", {16'h0, instr_compressed_o}, 32'h4501);
    id_in_ready_i = 1'b1;
    wait_grant("next_86", 32'h86);
    wait_grant("next_88", 32'h88);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check1("err_halt_no_req", s_req, 1'b0);
    end

    pc_set_i = 1'b1; pc_mux_i = 3'd2; exc_pc_mux_i = 2'd1;
    csr_mtvec_i = 32'h1001; exc_cause_i = 6'd7;
    tick();
    pc_set_i = 1'b0;
    wait_grant("irq_vector", 32'h101C);

    rsp_delay = 3;
    wait_grant("seq_1020", 32'h1020);
    sb_en = 1'b0;
    pc_set_i = 1'b1; pc_mux_i = 3'd1; branch_target_i = 32'h200;
    tick();
    pc_set_i = 1'b0;
    check1("flush_valid", instr_valid_o, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check1("discard_valid", instr_valid_o, 1'b0);
      check1("discard_no_req", s_req, 1'b0);
    end
    sb_en = 1'b1;
    rsp_delay = 1;
    wait_grant("jump_200", 32'h200);
    tick();

    gnt_en = 1'b0;
    tick();
    check1 ("stall_req", s_req, 1'b1);
    check32("stall_addr", s_addr, 32'h204);
    for (int i = 0; i < 10; i++) begin
      pc_set_i = 1'b1;
      pc_mux_i = vecs[i].pc_mux; exc_pc_mux_i = vecs[i].exc_mux; exc_cause_i = vecs[i].cause;
      csr_mtvec_i = vecs[i].mtvec; branch_target_i = vecs[i].target;
      csr_mepc_i = vecs[i].mepc; csr_depc_i = vecs[i].depc;
      tick();
      check32($sformatf("redir_%0d_addr", i), s_addr, vecs[i].exp);
      check1 ($sformatf("redir_%0d_req", i), s_req, 1'b1);
    end
    pc_set_i = 1'b0;
    tick();
    check32("redir_hold", s_addr, vecs[9].exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
